// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin sharing of one free-running binary-to-BCD
// converter among N requesters. The selected value is held on conv_data for
// CONV_LAT cycles, then the converter output is captured and tagged.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no conversion in flight; pick next requester round-robin
// WAIT  | conv_data held; counting settle time before sampling
module bcd_conv_arbiter #(
  parameter int N        = 4,
  parameter int CONV_LAT = 50,
  parameter int MAX_VAL  = 999
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [N-1:0]      req,
  input  logic [N*10-1:0]   req_data,
  output logic [N-1:0]      ack,
  output logic [N-1:0]      done,
  output logic [11:0]       bcd_out,
  output logic              ovf,
  output logic              busy,
  output logic [9:0]        conv_data,
  input  logic [11:0]       conv_bcd
);

  localparam int          IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [9:0]  MAX_V    = 10'(MAX_VAL);
  localparam logic [5:0]  CNT_LAST = 6'(CONV_LAT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [5:0]    cnt, cnt_nxt;
  logic          ovf_pend, ovf_pend_nxt;
  logic [N-1:0]  ack_nxt, done_nxt;
  logic [11:0]   bcd_nxt;
  logic          ovf_nxt, busy_nxt;
  logic [9:0]    conv_nxt;

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] cand;
  logic [9:0]    sel_val;
  logic [9:0]    req_val [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign req_val[g] = req_data[g*10 +: 10];
  end

  // Round-robin pick: first set req bit after ptr, wrapping modulo N
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_val   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
        sel_val   = req_val[cand];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    idx_nxt      = idx;
    cnt_nxt      = cnt;
    ovf_pend_nxt = ovf_pend;
    ack_nxt      = '0;
    done_nxt     = '0;
    bcd_nxt      = bcd_out;
    ovf_nxt      = 1'b0;
    busy_nxt     = busy;
    conv_nxt     = conv_data;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (sel_found) begin
          idx_nxt          = sel_idx;
          ack_nxt[sel_idx] = 1'b1;
          conv_nxt         = (sel_val > MAX_V) ? MAX_V : sel_val;
          ovf_pend_nxt     = (sel_val > MAX_V);
          cnt_nxt          = '0;
          state_nxt        = WAIT;
          busy_nxt         = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) begin
          bcd_nxt       = conv_bcd;
          done_nxt[idx] = 1'b1;
          ovf_nxt       = ovf_pend;
          ptr_nxt       = idx;
          state_nxt     = IDLE;
          busy_nxt      = 1'b0;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      ptr       <= IW'(N - 1);
      idx       <= '0;
      cnt       <= '0;
      ovf_pend  <= 1'b0;
      ack       <= '0;
      done      <= '0;
      bcd_out   <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      conv_data <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      ovf_pend  <= ovf_pend_nxt;
      ack       <= ack_nxt;
      done      <= done_nxt;
      bcd_out   <= bcd_nxt;
      ovf       <= ovf_nxt;
      busy      <= busy_nxt;
      conv_data <= conv_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Testbench for bcd_conv_arbiter: behavioural 24-cycle converter, directed
// stimulus, and a queue-based scoreboard checked by an independent monitor.
module tb_bcd_conv_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  req = '0;
  logic [39:0] req_data = '0;
  logic [3:0]  ack, done;
  logic [11:0] bcd_out;
  logic        ovf, busy;
  logic [9:0]  conv_data;
  logic [11:0] conv_bcd = '0;

  bcd_conv_arbiter #(.N(4), .CONV_LAT(50), .MAX_VAL(999)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .done      (done),
    .bcd_out   (bcd_out),
    .ovf       (ovf),
    .busy      (busy),
    .conv_data (conv_data),
    .conv_bcd  (conv_bcd)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Free-running converter: latch input once per 24-cycle period, publish
  // the BCD of the previous latch at the same boundary.
  logic [4:0] conv_ph = '0;
  logic [9:0] conv_in = '0;

  function automatic logic [11:0] to_bcd(input logic [9:0] v);
    int x;
    x = int'(v);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  always @(posedge sys_clk) begin
    if (conv_ph == 5'd23) begin
      conv_ph  <= '0;
      conv_bcd <= to_bcd(conv_in);
      conv_in  <= conv_data;
    end else begin
      conv_ph <= conv_ph + 5'd1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [3:0]  done;
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;

  int   ack_q [$];
  exp_t done_q [$];
  int   last_ack_cyc = 0;
  int   ea;
  exp_t ed;

  // Monitor: compares every ack/done the DUT presents against the queues
  always @(negedge sys_clk) begin
    if (ack != 4'b0) begin
      if (ack_q.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        ea = ack_q.pop_front();
        check("ack_order", 32'(ack), 32'(4'b1 << ea));
      end
      check("busy_at_ack", 32'(busy), 32'h1);
      last_ack_cyc = cyc;
    end
    if (done != 4'b0) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'h0);
      end else begin
        ed = done_q.pop_front();
        check("done_tag", 32'(done), 32'(ed.done));
        check("bcd_out", 32'(bcd_out), 32'(ed.bcd));
        check("ovf", 32'(ovf), 32'(ed.ovf));
      end
      check("busy_at_done", 32'(busy), 32'h0);
      check("done_latency", 32'(cyc - last_ack_cyc), 32'd50);
    end
  end

  task automatic set_data(input int i, input logic [9:0] v);
    req_data[i*10 +: 10] = v;
  endtask

  task automatic push_done(input logic [3:0] d, input logic [11:0] b, input logic o);
    exp_t e;
    e.done = d;
    e.bcd  = b;
    e.ovf  = o;
    done_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_bcd_out"}, 32'(bcd_out), 32'h0);
    check({tag, "_ovf"}, 32'(ovf), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_conv_data"}, 32'(conv_data), 32'h0);
  endtask

  task automatic do_reset();
    req     = '0;
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
  endtask

  task automatic wait_ack(output bit ok);
    int waited = 0;
    do begin
      @(negedge sys_clk);
      waited++;
    end while (ack == 4'b0 && waited < 200);
    ok = (ack != 4'b0);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: got no ack after %0d cycles, required one", waited);
    end
  endtask

  task automatic wait_done();
    int waited = 0;
    do begin
      @(negedge sys_clk);
      waited++;
    end while (done == 4'b0 && waited < 200);
    if (done == 4'b0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, required one", waited);
    end else begin
      @(negedge sys_clk);
      check("done_pulse", 32'(done), 32'h0);
    end
  endtask

  // Hold mask for n acks, checking ack width and back-to-back spacing
  task automatic run_services(input logic [3:0] mask, input int n);
    int prev = -1;
    bit ok;
    req = mask;
    for (int s = 0; s < n; s++) begin
      wait_ack(ok);
      if (!ok) break;
      if (prev >= 0) check("ack_spacing", 32'(cyc - prev), 32'd51);
      prev = cyc;
      if (s == n - 1) req = '0;
      @(negedge sys_clk);
      check("ack_pulse", 32'(ack), 32'h0);
    end
    req = '0;
    wait_done();
  endtask

  initial begin
    bit ok;

    // Reset state
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check_reset_outputs("reset");

    // 1: single request
    set_data(0, 10'd345);
    ack_q.push_back(0);
    push_done(4'b0001, 12'h345, 1'b0);
    run_services(4'b0001, 1);

    // 2: two requesters back to back, boundary value 999
    do_reset();
    set_data(0, 10'd7);
    set_data(2, 10'd999);
    ack_q.push_back(0);
    ack_q.push_back(2);
    push_done(4'b0001, 12'h007, 1'b0);
    push_done(4'b0100, 12'h999, 1'b0);
    run_services(4'b0101, 2);

    // 3: all four held, ten services in rotation
    do_reset();
    set_data(0, 10'd1);
    set_data(1, 10'd20);
    set_data(2, 10'd300);
    set_data(3, 10'd999);
    for (int s = 0; s < 10; s++) begin
      ack_q.push_back(s % 4);
      case (s % 4)
        0: push_done(4'b0001, 12'h001, 1'b0);
        1: push_done(4'b0010, 12'h020, 1'b0);
        2: push_done(4'b0100, 12'h300, 1'b0);
        default: push_done(4'b1000, 12'h999, 1'b0);
      endcase
    end
    run_services(4'b1111, 10);

    // 4: clamp boundaries
    set_data(1, 10'd1023);
    ack_q.push_back(1);
    push_done(4'b0010, 12'h999, 1'b1);
    run_services(4'b0010, 1);
    set_data(1, 10'd1000);
    ack_q.push_back(1);
    push_done(4'b0010, 12'h999, 1'b1);
    run_services(4'b0010, 1);
    set_data(1, 10'd0);
    ack_q.push_back(1);
    push_done(4'b0010, 12'h000, 1'b0);
    run_services(4'b0010, 1);

    // 5: reset at cnt=20 of a service for requester 2
    set_data(2, 10'd77);
    ack_q.push_back(2);
    req = 4'b0100;
    wait_ack(ok);
    req = '0;
    repeat (20) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check_reset_outputs("abort");
    set_data(1, 10'd58);
    ack_q.push_back(1);
    push_done(4'b0010, 12'h058, 1'b0);
    run_services(4'b0110, 1);

    // 6: req[3] pulsed during WAIT is never served; data0 captured at ack
    set_data(0, 10'd123);
    ack_q.push_back(0);
    push_done(4'b0001, 12'h123, 1'b0);
    req = 4'b0001;
    wait_ack(ok);
    req = '0;
    repeat (5) @(negedge sys_clk);
    req = 4'b1000;
    set_data(0, 10'd456);
    repeat (3) @(negedge sys_clk);
    req = '0;
    wait_done();
    repeat (60) @(negedge sys_clk);

    check("ack_q_drained", 32'(ack_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
